// File: rtl/adder_result_checker_if.sv
// Bundles the adder-checker signals: the applied vector, the reference and DUT adder results,
// and the checker status outputs.
interface adder_result_checker_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = 16
);
    logic          start;
    logic          vec_valid;
    logic          vec_last;
    logic          chk_pg;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          cin;
    logic [N-1:0]  ref_s;
    logic          ref_cout;
    logic          ref_prop;
    logic          ref_gen;
    logic [N-1:0]  dut_s;
    logic          dut_cout;
    logic          dut_prop;
    logic          dut_gen;
    logic          busy;
    logic          done;
    logic          pass;
    logic [CW-1:0] vec_count;
    logic [CW-1:0] err_count;
    logic          fail_valid;
    logic [N-1:0]  fail_a;
    logic [N-1:0]  fail_b;
    logic          fail_cin;

    modport master (
        output start, vec_valid, vec_last, chk_pg, a, b, cin,
        output ref_s, ref_cout, ref_prop, ref_gen,
        output dut_s, dut_cout, dut_prop, dut_gen,
        input  busy, done, pass, vec_count, err_count,
        input  fail_valid, fail_a, fail_b, fail_cin
    );

    modport slave (
        input  start, vec_valid, vec_last, chk_pg, a, b, cin,
        input  ref_s, ref_cout, ref_prop, ref_gen,
        input  dut_s, dut_cout, dut_prop, dut_gen,
        output busy, done, pass, vec_count, err_count,
        output fail_valid, fail_a, fail_b, fail_cin
    );
endinterface

// File: rtl/adder_result_checker.sv
// Compares a possibly pipelined adder against a combinational reference: the reference result
// is delayed LAT cycles, then vectors and mismatches are counted and the first failure captured.
module adder_result_checker #(
    parameter int unsigned N   = 4,
    parameter int unsigned LAT = 0,
    parameter int unsigned CW  = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    adder_result_checker_if.slave io_chk
);
    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

    typedef struct packed {
        logic [N-1:0] s;
        logic         cout;
        logic         prop;
        logic         gen;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic         chk_pg;
        logic         last;
    } entry_t;

    state_t        r_state;
    state_t        w_state_next;
    entry_t        w_in;
    entry_t        w_cmp;
    logic          w_push;
    logic          w_cmp_vld;
    logic          w_fire;
    logic          w_mismatch;
    logic [CW-1:0] r_vec_count;
    logic [CW-1:0] r_err_count;
    logic          r_fail_valid;
    logic [N-1:0]  r_fail_a;
    logic [N-1:0]  r_fail_b;
    logic          r_fail_cin;

    // Vectors are only accepted while running; a vector alongside start belongs to no run.
    assign w_push = (r_state == StRun) && io_chk.vec_valid && !io_chk.start;
    assign w_in   = {io_chk.ref_s, io_chk.ref_cout, io_chk.ref_prop, io_chk.ref_gen,
                     io_chk.a, io_chk.b, io_chk.cin, io_chk.chk_pg, io_chk.vec_last};

    generate
        if (LAT == 0) begin : g_bypass
            assign w_cmp_vld = w_push;
            assign w_cmp     = w_in;
        end else begin : g_delay
            entry_t           r_dly [LAT];
            logic [LAT-1:0]   r_dly_vld;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dly_vld <= '0;
                    for (int i = 0; i < LAT; i++) begin
                        r_dly[i] <= '0;
                    end
                end else begin
                    r_dly[0]     <= w_in;
                    r_dly_vld[0] <= w_push;
                    for (int i = 1; i < LAT; i++) begin
                        r_dly[i]     <= r_dly[i-1];
                        r_dly_vld[i] <= r_dly_vld[i-1];
                    end
                    if (io_chk.start) begin
                        r_dly_vld <= '0;
                    end
                end
            end

            assign w_cmp_vld = r_dly_vld[LAT-1];
            assign w_cmp     = r_dly[LAT-1];
        end
    endgenerate

    assign w_fire = w_cmp_vld && !io_chk.start && ((r_state == StRun) || (r_state == StDrain));

    assign w_mismatch = (w_cmp.s != io_chk.dut_s) || (w_cmp.cout != io_chk.dut_cout) ||
                        (w_cmp.chk_pg && ((w_cmp.prop != io_chk.dut_prop) ||
                                          (w_cmp.gen != io_chk.dut_gen)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (io_chk.start) begin
            w_state_next = StRun;
        end else begin
            unique case (r_state)
                StIdle:  w_state_next = StIdle;
                StRun: begin
                    if (w_push && io_chk.vec_last) begin
                        w_state_next = (LAT == 0) ? StDone : StDrain;
                    end
                end
                StDrain: begin
                    if (w_fire && w_cmp.last) begin
                        w_state_next = StDone;
                    end
                end
                StDone:  w_state_next = StDone;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec_count  <= '0;
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
            r_fail_cin   <= 1'b0;
        end else if (io_chk.start) begin
            r_vec_count  <= '0;
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
            r_fail_cin   <= 1'b0;
        end else if (w_fire) begin
            // Both counters stick at all-ones rather than wrapping.
            if (r_vec_count != '1) begin
                r_vec_count <= r_vec_count + 1'b1;
            end
            if (w_mismatch) begin
                if (r_err_count != '1) begin
                    r_err_count <= r_err_count + 1'b1;
                end
                if (!r_fail_valid) begin
                    r_fail_valid <= 1'b1;
                    r_fail_a     <= w_cmp.a;
                    r_fail_b     <= w_cmp.b;
                    r_fail_cin   <= w_cmp.cin;
                end
            end
        end
    end

    assign io_chk.busy       = (r_state == StRun) || (r_state == StDrain);
    assign io_chk.done       = (r_state == StDone);
    assign io_chk.pass       = (r_state == StDone) && (r_err_count == '0);
    assign io_chk.vec_count  = r_vec_count;
    assign io_chk.err_count  = r_err_count;
    assign io_chk.fail_valid = r_fail_valid;
    assign io_chk.fail_a     = r_fail_a;
    assign io_chk.fail_b     = r_fail_b;
    assign io_chk.fail_cin   = r_fail_cin;
endmodule

// File: tb/tb_adder_result_checker.sv
// Drives three checker instances (LAT/CW = 0/16, 2/16, 3/4) from one stimulus stream and
// scores them against a saturating-count model through per-instance expectation queues.
module tb_adder_result_checker;
    localparam int unsigned N  = 4;
    localparam int          NI = 3;
    localparam int          LATS [NI] = '{0, 2, 3};
    localparam int          CWS  [NI] = '{16, 16, 4};

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic         e_s;
        logic         e_cout;
        logic         e_prop;
        logic         e_gen;
    } vin_t;

    typedef struct {
        int           due;
        int           vec;
        int           err;
        bit           last;
        bit           fv;
        logic [N-1:0] fa;
        logic [N-1:0] fb;
        logic         fcin;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, vec_valid, vec_last, chk_pg, cin;
    logic [N-1:0] a, b;
    logic         e_s, e_cout, e_prop, e_gen;
    logic [N-1:0] ref_s;
    logic         ref_cout, ref_prop, ref_gen;
    vin_t         cur;
    vin_t         hist [4];
    int           cyc = 0;

    logic         o_busy [NI];
    logic         o_done [NI];
    logic         o_pass [NI];
    logic         o_fv   [NI];
    logic         o_fcin [NI];
    logic [31:0]  o_vec  [NI];
    logic [31:0]  o_err  [NI];
    logic [N-1:0] o_fa   [NI];
    logic [N-1:0] o_fb   [NI];

    exp_t sbq [NI][$];
    int   total = 0;
    int   bad   = 0;

    // Run-level model: unsaturated counts; each instance sees them clipped to its own CW.
    bit           m_run = 0;
    int           m_vec = 0;
    int           m_err = 0;
    bit           m_fv  = 0;
    logic [N-1:0] m_fa  = '0;
    logic [N-1:0] m_fb  = '0;
    logic         m_fcin = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign {ref_cout, ref_s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    assign ref_prop = &(a ^ b);
    assign ref_gen  = (32'(a) + 32'(b)) > ((1 << N) - 1);
    assign cur      = {a, b, cin, e_s, e_cout, e_prop, e_gen};

    always @(posedge clk) begin
        hist[0] <= cur;
        for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
    end

    // Adder under test: a correct adder whose selected outputs are inverted on request.
    function automatic logic [N+2:0] dut_model(input vin_t v);
        logic [N:0]   gsum;
        logic [N:0]   sum;
        logic [N-1:0] s;
        gsum = {1'b0, v.a} + {1'b0, v.b};
        sum  = gsum + {{N{1'b0}}, v.cin};
        s    = sum[N-1:0] ^ {{(N-1){1'b0}}, v.e_s};
        return {s, sum[N] ^ v.e_cout, (&(v.a ^ v.b)) ^ v.e_prop, gsum[N] ^ v.e_gen};
    endfunction

    for (genvar k = 0; k < NI; k++) begin : g_inst
        localparam int L = LATS[k];
        logic [N+2:0] w_dut;

        adder_result_checker_if #(.N(N), .CW(CWS[k])) u_if ();

        if (L == 0) begin : g_l0
            assign w_dut = dut_model(cur);
        end else begin : g_ln
            assign w_dut = dut_model(hist[L-1]);
        end

        assign u_if.start     = start;
        assign u_if.vec_valid = vec_valid;
        assign u_if.vec_last  = vec_last;
        assign u_if.chk_pg    = chk_pg;
        assign u_if.a         = a;
        assign u_if.b         = b;
        assign u_if.cin       = cin;
        assign u_if.ref_s     = ref_s;
        assign u_if.ref_cout  = ref_cout;
        assign u_if.ref_prop  = ref_prop;
        assign u_if.ref_gen   = ref_gen;
        assign u_if.dut_s     = w_dut[N+2:3];
        assign u_if.dut_cout  = w_dut[2];
        assign u_if.dut_prop  = w_dut[1];
        assign u_if.dut_gen   = w_dut[0];

        adder_result_checker #(.N(N), .LAT(L), .CW(CWS[k])) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .io_chk (u_if.slave)
        );

        assign o_busy[k] = u_if.busy;
        assign o_done[k] = u_if.done;
        assign o_pass[k] = u_if.pass;
        assign o_fv[k]   = u_if.fail_valid;
        assign o_fcin[k] = u_if.fail_cin;
        assign o_vec[k]  = 32'(u_if.vec_count);
        assign o_err[k]  = 32'(u_if.err_count);
        assign o_fa[k]   = u_if.fail_a;
        assign o_fb[k]   = u_if.fail_b;
    end

    function automatic int sat(input int x, input int cw);
        int mx;
        mx = (1 << cw) - 1;
        return (x > mx) ? mx : x;
    endfunction

    function automatic void check(input string nm, input int k, input logic [31:0] act,
                                  input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d (LAT=%0d): got %0d expected %0d at cycle %0d",
                     nm, k, LATS[k], act, exp, cyc);
        end
    endfunction

    // Monitor: every result becomes visible LAT+1 cycles after its vector was applied.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                while (sbq[k].size() > 0 && sbq[k][0].due <= cyc) begin
                    e = sbq[k].pop_front();
                    check("sb_due", k, cyc, e.due);
                    check("sb_vec_count", k, o_vec[k], e.vec);
                    check("sb_err_count", k, o_err[k], e.err);
                    check("sb_done", k, o_done[k], e.last);
                    check("sb_busy", k, o_busy[k], !e.last);
                    check("sb_pass", k, o_pass[k], e.last && (e.err == 0));
                    check("sb_fail_valid", k, o_fv[k], e.fv);
                    if (e.fv) begin
                        check("sb_fail_a", k, o_fa[k], e.fa);
                        check("sb_fail_b", k, o_fb[k], e.fb);
                        check("sb_fail_cin", k, o_fcin[k], e.fcin);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic put_vec(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vc,
                           input logic vpg, input logic vlast, input logic ves,
                           input logic vecout, input logic vep, input logic veg);
        bit mis;
        a = va; b = vb; cin = vc; chk_pg = vpg; vec_last = vlast;
        e_s = ves; e_cout = vecout; e_prop = vep; e_gen = veg;
        vec_valid = 1'b1;
        if (m_run && !start) begin
            mis = ves || vecout || (vpg && (vep || veg));
            m_vec++;
            if (mis) begin
                m_err++;
                if (!m_fv) begin
                    m_fv = 1; m_fa = va; m_fb = vb; m_fcin = vc;
                end
            end
            for (int k = 0; k < NI; k++) begin
                sbq[k].push_back('{due: cyc + LATS[k] + 1, vec: sat(m_vec, CWS[k]),
                                   err: sat(m_err, CWS[k]), last: vlast, fv: m_fv,
                                   fa: m_fa, fb: m_fb, fcin: m_fcin});
            end
            if (vlast) m_run = 0;
        end
        @(negedge clk);
        vec_valid = 1'b0; vec_last = 1'b0;
        e_s = 1'b0; e_cout = 1'b0; e_prop = 1'b0; e_gen = 1'b0;
    endtask

    task automatic put_rand(input logic vlast, input logic ves);
        put_vec(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                1'b1, vlast, ves, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        vec_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic model_clear();
        m_vec = 0; m_err = 0; m_fv = 0; m_fa = '0; m_fb = '0; m_fcin = 1'b0;
    endtask

    task automatic do_start(input bit with_vec);
        start = 1'b1;
        model_clear();
        if (with_vec) put_vec(4'h1, 4'h2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        else @(negedge clk);
        start = 1'b0;
        m_run = 1;
        for (int k = 0; k < NI; k++) begin
            check("start_vec_clear", k, o_vec[k], 0);
            check("start_err_clear", k, o_err[k], 0);
            check("start_fail_clear", k, o_fv[k], 0);
            check("start_busy", k, o_busy[k], 1);
        end
    endtask

    task automatic check_zero(input string tag);
        for (int k = 0; k < NI; k++) begin
            check({tag, "_busy"}, k, o_busy[k], 0);
            check({tag, "_done"}, k, o_done[k], 0);
            check({tag, "_pass"}, k, o_pass[k], 0);
            check({tag, "_vec"}, k, o_vec[k], 0);
            check({tag, "_err"}, k, o_err[k], 0);
            check({tag, "_fv"}, k, o_fv[k], 0);
            check({tag, "_fa"}, k, o_fa[k], 0);
            check({tag, "_fb"}, k, o_fb[k], 0);
            check({tag, "_fcin"}, k, o_fcin[k], 0);
        end
    endtask

    task automatic check_final(input string tag);
        for (int k = 0; k < NI; k++) begin
            check({tag, "_done"}, k, o_done[k], 1);
            check({tag, "_busy"}, k, o_busy[k], 0);
            check({tag, "_vec"}, k, o_vec[k], sat(m_vec, CWS[k]));
            check({tag, "_err"}, k, o_err[k], sat(m_err, CWS[k]));
            check({tag, "_pass"}, k, o_pass[k], m_err == 0);
            check({tag, "_fv"}, k, o_fv[k], m_fv);
            if (m_fv) begin
                check({tag, "_fa"}, k, o_fa[k], m_fa);
                check({tag, "_fb"}, k, o_fb[k], m_fb);
                check({tag, "_fcin"}, k, o_fcin[k], m_fcin);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; vec_valid = 1'b0; vec_last = 1'b0; chk_pg = 1'b0;
        a = '0; b = '0; cin = 1'b0; e_s = 1'b0; e_cout = 1'b0; e_prop = 1'b0; e_gen = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("in_reset");
        rst_n = 1'b1;
        idle(2);
        check_zero("after_reset");

        // Exhaustive operand sweep, all matching.
        do_start(0);
        for (int i = 0; i < 256; i++) begin
            put_vec(4'(i >> 4), 4'(i), 1'($urandom_range(0, 1)), 1'b1, i == 255,
                    1'b0, 1'b0, 1'b0, 1'b0);
        end
        idle(6);
        check_final("sweep");
        for (int k = 0; k < NI; k++) check("sweep_vec256", k, o_vec[k], sat(256, CWS[k]));

        // Vectors while DONE must be ignored.
        for (int i = 0; i < 3; i++) put_rand(1'b0, 1'b1);
        idle(4);
        check_final("done_ignore");

        // Start from DONE with a simultaneous (ignored) bad vector; mismatches at 5 and 9.
        do_start(1);
        for (int i = 0; i < 12; i++) begin
            if (i == 5) put_vec(4'h3, 4'h5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            else if (i == 9) put_vec(4'h9, 4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            else put_rand(i == 11, 1'b0);
            if (i < 11) idle($urandom_range(0, 2));
        end
        for (int j = 1; j <= 5; j++) begin
            for (int k = 0; k < NI; k++) check("done_rise", k, o_done[k], j > LATS[k]);
            put_rand(1'b0, 1'b1);
        end
        idle(3);
        check_final("two_err");
        for (int k = 0; k < NI; k++) begin
            check("two_err_count", k, o_err[k], 2);
            check("two_err_fail_a", k, o_fa[k], 3);
            check("two_err_fail_b", k, o_fb[k], 5);
            check("two_err_fail_cin", k, o_fcin[k], 1);
        end

        // prop/gen are only compared when chk_pg is set.
        do_start(0);
        put_vec(4'h6, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        put_vec(4'h5, 4'ha, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(5);
        for (int k = 0; k < NI; k++) check("pg_masked_err", k, o_err[k], 0);
        put_vec(4'h6, 4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(5);
        check_final("pg");
        for (int k = 0; k < NI; k++) check("pg_checked_err", k, o_err[k], 1);

        // Saturation: 20 mismatching vectors.
        do_start(0);
        for (int i = 0; i < 20; i++) put_rand(i == 19, 1'b1);
        idle(6);
        check_final("sat");

        // Asynchronous reset while draining.
        do_start(0);
        for (int i = 0; i < 6; i++) put_rand(i == 5, 1'b0);
        #1 rst_n = 1'b0;
        #1 check_zero("reset_drain");
        for (int k = 0; k < NI; k++) sbq[k].delete();
        model_clear();
        m_run = 0;
        @(negedge clk);
        rst_n = 1'b1;
        put_rand(1'b0, 1'b1);
        put_rand(1'b1, 1'b1);
        idle(2);
        check_zero("idle_after_reset");
        do_start(0);
        for (int i = 0; i < 4; i++) put_rand(i == 3, 1'b0);
        idle(6);
        check_final("restart");
        for (int k = 0; k < NI; k++) check("restart_vec4", k, o_vec[k], 4);

        // Random mix of errors, chk_pg and bubbles.
        do_start(0);
        for (int i = 0; i < 40; i++) begin
            put_vec(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), i == 39,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
            if (i < 39 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(6);
        check_final("random");

        for (int k = 0; k < NI; k++) check("sb_drained", k, sbq[k].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
